// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed MIPS loads/stores into word accesses on a
// word-addressed memory, with read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH_MEM = 32,
  parameter int MEM_DEPTH  = 32
) (
  input  logic                  ls_clk,
  input  logic                  ls_rst,
  input  logic                  ls_i_valid,
  input  logic                  ls_i_load,
  input  logic                  ls_i_store,
  input  logic [1:0]            ls_i_size,
  input  logic                  ls_i_unsigned,
  input  logic [31:0]           ls_i_addr,
  input  logic [DWIDTH-1:0]     ls_i_store_data,
  output logic                  ls_o_stall,
  output logic                  ls_o_done,
  output logic                  ls_o_err,
  output logic [DWIDTH-1:0]     ls_o_load_data,
  output logic                  ls_o_ce,
  output logic                  ls_o_wr_en,
  output logic                  ls_o_rd_en,
  output logic [AWIDTH_MEM-1:0] ls_o_addr,
  output logic [DWIDTH-1:0]     ls_o_store_data,
  input  logic [DWIDTH-1:0]     ls_i_mem_data
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, LOAD_RESP, RMW_READ} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t                  state, next_state;
  logic [29:0]             in_idx;
  logic                    req_err;
  logic                    accept;
  logic [AWIDTH_MEM-1:0]   idx_q;
  logic [1:0]              off_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [15:0]             sdata_q;
  logic [7:0]              lane_byte;
  logic [15:0]             lane_half;
  logic [DWIDTH-1:0]       load_ext;
  logic [DWIDTH-1:0]       merged;

  assign in_idx = ls_i_addr[31:2];
  assign accept = (state == IDLE) && ls_i_valid && !ls_rst;

  always_comb begin
    req_err = 1'b0;
    if (ls_i_load == ls_i_store)                              req_err = 1'b1;
    if (ls_i_size == 2'b11)                                   req_err = 1'b1;
    if (ls_i_size == SZ_HALF && ls_i_addr[0])                 req_err = 1'b1;
    if (ls_i_size == SZ_WORD && ls_i_addr[1:0] != 2'b00)      req_err = 1'b1;
    if ({2'b00, in_idx} >= 32'(MEM_DEPTH))                    req_err = 1'b1;
  end

  // NOTE: request fields are pure datapath qualified by state, so they carry no reset.
  always_ff @(posedge ls_clk) begin
    if (accept) begin
      idx_q   <= AWIDTH_MEM'({2'b00, in_idx});
      off_q   <= ls_i_addr[1:0];
      size_q  <= ls_i_size;
      uns_q   <= ls_i_unsigned;
      sdata_q <= ls_i_store_data[15:0];
    end
  end

  // Little-endian lane select on the word returned by memory.
  always_comb begin
    lane_byte = ls_i_mem_data[{off_q, 3'b000} +: 8];
    lane_half = ls_i_mem_data[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {{(DWIDTH-8){1'b0}}, lane_byte}
                                : {{(DWIDTH-8){lane_byte[7]}}, lane_byte};
      SZ_HALF: load_ext = uns_q ? {{(DWIDTH-16){1'b0}}, lane_half}
                                : {{(DWIDTH-16){lane_half[15]}}, lane_half};
      default: load_ext = ls_i_mem_data;
    endcase
  end

  always_comb begin
    merged = ls_i_mem_data;
    if (size_q == SZ_BYTE) merged[{off_q, 3'b000} +: 8]     = sdata_q[7:0];
    else                   merged[{off_q[1], 4'b0000} +: 16] = sdata_q;
  end

  always_comb begin
    next_state      = state;
    ls_o_ce         = 1'b0;
    ls_o_wr_en      = 1'b0;
    ls_o_rd_en      = 1'b0;
    ls_o_stall      = 1'b0;
    ls_o_addr       = idx_q;
    ls_o_store_data = '0;
    case (state)
      IDLE: begin
        ls_o_addr = AWIDTH_MEM'({2'b00, in_idx});
        if (ls_i_valid && !req_err) begin
          ls_o_ce = 1'b1;
          if (ls_i_store && ls_i_size == SZ_WORD) begin
            ls_o_wr_en      = 1'b1;
            ls_o_store_data = ls_i_store_data;
          end else begin
            ls_o_rd_en = 1'b1;
            ls_o_stall = 1'b1;
            next_state = ls_i_load ? LOAD_WAIT : RMW_READ;
          end
        end
      end
      LOAD_WAIT: begin
        ls_o_stall = 1'b1;
        next_state = LOAD_RESP;
      end
      LOAD_RESP: next_state = IDLE;
      RMW_READ: begin
        ls_o_ce         = 1'b1;
        ls_o_wr_en      = 1'b1;
        ls_o_store_data = merged;
        next_state      = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // NOTE: reset gates the enables combinationally so an in-flight RMW write is never issued.
    if (ls_rst) begin
      ls_o_ce    = 1'b0;
      ls_o_wr_en = 1'b0;
      ls_o_rd_en = 1'b0;
      ls_o_stall = 1'b0;
      next_state = IDLE;
    end
  end

  always_ff @(posedge ls_clk) begin
    if (ls_rst) begin
      state          <= IDLE;
      ls_o_load_data <= '0;
      ls_o_done      <= 1'b0;
      ls_o_err       <= 1'b0;
    end else begin
      state     <= next_state;
      ls_o_done <= 1'b0;
      ls_o_err  <= 1'b0;
      if (state == IDLE && ls_i_valid) begin
        if (req_err)                                   ls_o_err  <= 1'b1;
        else if (ls_i_store && ls_i_size == SZ_WORD)   ls_o_done <= 1'b1;
      end
      if (state == LOAD_WAIT) begin
        ls_o_load_data <= load_ext;
        ls_o_done      <= 1'b1;
      end
      if (state == RMW_READ) ls_o_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural word memory, scoreboard queue
// of expected load results / RMW words, cycle-exact checks of enables and pulses.
module tb_load_store_unit;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 32;

  logic          ls_clk, ls_rst;
  logic          ls_i_valid, ls_i_load, ls_i_store, ls_i_unsigned;
  logic [1:0]    ls_i_size;
  logic [31:0]   ls_i_addr;
  logic [DW-1:0] ls_i_store_data, ls_i_mem_data;
  logic          ls_o_stall, ls_o_done, ls_o_err, ls_o_ce, ls_o_wr_en, ls_o_rd_en;
  logic [DW-1:0] ls_o_load_data, ls_o_store_data;
  logic [AW-1:0] ls_o_addr;

  load_store_unit #(.DWIDTH(DW), .AWIDTH_MEM(AW), .MEM_DEPTH(DEPTH)) dut (
    .ls_clk(ls_clk), .ls_rst(ls_rst), .ls_i_valid(ls_i_valid), .ls_i_load(ls_i_load),
    .ls_i_store(ls_i_store), .ls_i_size(ls_i_size), .ls_i_unsigned(ls_i_unsigned),
    .ls_i_addr(ls_i_addr), .ls_i_store_data(ls_i_store_data), .ls_o_stall(ls_o_stall),
    .ls_o_done(ls_o_done), .ls_o_err(ls_o_err), .ls_o_load_data(ls_o_load_data),
    .ls_o_ce(ls_o_ce), .ls_o_wr_en(ls_o_wr_en), .ls_o_rd_en(ls_o_rd_en),
    .ls_o_addr(ls_o_addr), .ls_o_store_data(ls_o_store_data), .ls_i_mem_data(ls_i_mem_data)
  );

  initial ls_clk = 1'b0;
  always #5 ls_clk = ~ls_clk;

  // Behavioural synchronous memory: read data valid the cycle after rd_en.
  logic [31:0] mem [DEPTH];
  logic [31:0] mem_rd;
  logic        mem_init;
  always @(posedge ls_clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h1122_3344;
      mem[2] <= 32'hDEAD_BEEF;
      mem_rd <= 32'h0;
    end else if (ls_o_ce && ls_o_addr < DEPTH) begin
      if (ls_o_wr_en) mem[ls_o_addr[4:0]] <= ls_o_store_data;
      if (ls_o_rd_en) mem_rd <= mem[ls_o_addr[4:0]];
    end
  end
  assign ls_i_mem_data = mem_rd;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb_q [$];
  logic [31:0] last_load = 32'h0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  task automatic check_pop(input string tag, input logic [31:0] actual);
    if (sb_q.size() == 0) check({tag, " scoreboard empty"}, 32'd1, 32'd0);
    else check(tag, actual, sb_q.pop_front());
  endtask

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data);
    ls_i_valid = 1'b1; ls_i_load = ld; ls_i_store = st; ls_i_size = sz;
    ls_i_unsigned = uns; ls_i_addr = addr; ls_i_store_data = data;
  endtask

  task automatic idle_in();
    ls_i_valid = 1'b0; ls_i_load = 1'b0; ls_i_store = 1'b0;
  endtask

  // {ce, rd_en, wr_en, stall}
  function automatic logic [31:0] en_vec();
    return {28'h0, ls_o_ce, ls_o_rd_en, ls_o_wr_en, ls_o_stall};
  endfunction

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp);
    @(negedge ls_clk);
    drive(1'b1, 1'b0, sz, uns, addr, 32'h0);
    sb_q.push_back(exp);
    #1;
    check({tag, " c0 enables"}, en_vec(), 32'b1101);
    check({tag, " c0 addr"}, ls_o_addr, {2'b00, addr[31:2]});
    @(negedge ls_clk);
    check({tag, " c1 stall/done"}, {30'h0, ls_o_stall, ls_o_done}, 32'b10);
    @(negedge ls_clk);
    check({tag, " c2 stall/done"}, {30'h0, ls_o_stall, ls_o_done}, 32'b01);
    check_pop({tag, " load_data"}, ls_o_load_data);
    last_load = exp;
    idle_in();
  endtask

  task automatic do_store_sub(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] exp_word);
    @(negedge ls_clk);
    drive(1'b0, 1'b1, sz, 1'b0, addr, data);
    sb_q.push_back(exp_word);
    #1;
    check({tag, " c0 enables"}, en_vec(), 32'b1101);
    @(negedge ls_clk);
    check({tag, " c1 enables"}, en_vec(), 32'b1010);
    check({tag, " c1 addr"}, ls_o_addr, {2'b00, addr[31:2]});
    check_pop({tag, " c1 store_data"}, ls_o_store_data);
    idle_in();
    @(negedge ls_clk);
    check({tag, " c2 done"}, {31'h0, ls_o_done}, 32'd1);
  endtask

  task automatic do_err(input string tag, input logic ld, input logic st,
                        input logic [1:0] sz, input logic [31:0] addr);
    @(negedge ls_clk);
    drive(ld, st, sz, 1'b0, addr, 32'hFFFF_FFFF);
    #1;
    check({tag, " c0 enables"}, en_vec(), 32'b0000);
    @(negedge ls_clk);
    check({tag, " c1 err/done"}, {30'h0, ls_o_err, ls_o_done}, 32'b10);
    check({tag, " load_data kept"}, ls_o_load_data, last_load);
    idle_in();
    @(negedge ls_clk);
    check({tag, " c2 err"}, {31'h0, ls_o_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    ls_rst = 1'b1; mem_init = 1'b1;
    idle_in();
    ls_i_size = 2'b10; ls_i_unsigned = 1'b0; ls_i_addr = 32'h0; ls_i_store_data = 32'h0;
    repeat (2) @(negedge ls_clk);
    check("reset pulses", {29'h0, ls_o_done, ls_o_err, ls_o_stall}, 32'd0);
    check("reset load_data", ls_o_load_data, 32'h0);
    check("reset enables", en_vec(), 32'b0000);
    ls_rst = 1'b0; mem_init = 1'b0;

    // Loads from word 2 = 0xDEADBEEF
    do_load("lw 08",  2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF);
    do_load("lb 0B",  2'b00, 1'b0, 32'h0B, 32'hFFFF_FFDE);
    do_load("lbu 0B", 2'b00, 1'b1, 32'h0B, 32'h0000_00DE);
    do_load("lh 0A",  2'b01, 1'b0, 32'h0A, 32'hFFFF_DEAD);
    do_load("lhu 0A", 2'b01, 1'b1, 32'h0A, 32'h0000_DEAD);
    do_load("lb 08",  2'b00, 1'b0, 32'h08, 32'hFFFF_FFEF);
    do_load("lbu 09", 2'b00, 1'b1, 32'h09, 32'h0000_00BE);

    // Byte store via RMW, then read back
    do_store_sub("sb 09", 2'b00, 32'h09, 32'h0000_005A, 32'hDEAD_5AEF);
    do_load("lw 08 after sb", 2'b10, 1'b0, 32'h08, 32'hDEAD_5AEF);
    do_store_sub("sh 0A", 2'b01, 32'h0A, 32'h0000_1234, 32'h1234_5AEF);

    // Back-to-back word stores
    @(negedge ls_clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
    #1;
    check("sw 10 enables", en_vec(), 32'b1010);
    check("sw 10 addr", ls_o_addr, 32'd4);
    check("sw 10 store_data", ls_o_store_data, 32'h1234_5678);
    @(negedge ls_clk);
    check("sw 10 done", {31'h0, ls_o_done}, 32'd1);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFE_F00D);
    #1;
    check("sw 14 enables", en_vec(), 32'b1010);
    check("sw 14 addr", ls_o_addr, 32'd5);
    check("sw 14 store_data", ls_o_store_data, 32'hCAFE_F00D);
    @(negedge ls_clk);
    check("sw 14 done", {31'h0, ls_o_done}, 32'd1);
    idle_in();
    do_load("lw 10", 2'b10, 1'b0, 32'h10, 32'h1234_5678);
    do_load("lw 14", 2'b10, 1'b0, 32'h14, 32'hCAFE_F00D);

    // Rejected requests
    do_err("err lw 06",    1'b1, 1'b0, 2'b10, 32'h06);
    do_err("err lh 03",    1'b1, 1'b0, 2'b01, 32'h03);
    do_err("err lw 80",    1'b1, 1'b0, 2'b10, 32'h80);
    do_err("err size 11",  1'b1, 1'b0, 2'b11, 32'h08);
    do_err("err ld&st",    1'b1, 1'b1, 2'b10, 32'h08);
    do_err("err neither",  1'b0, 1'b0, 2'b10, 32'h08);

    // Reset during the RMW read cycle aborts the write
    @(negedge ls_clk);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h02, 32'h0000_BEEF);
    #1;
    check("rst sh c0 enables", en_vec(), 32'b1101);
    @(negedge ls_clk);
    ls_rst = 1'b1;
    #1;
    check("rst sh c1 enables", en_vec(), 32'b0000);
    @(negedge ls_clk);
    ls_rst = 1'b0;
    idle_in();
    check("rst sh after pulses", {29'h0, ls_o_done, ls_o_err, ls_o_stall}, 32'd0);
    check("rst sh mem word 0", mem[0], 32'h1122_3344);
    @(negedge ls_clk);
    check("rst sh no late done", {30'h0, ls_o_done, ls_o_err}, 32'd0);
    last_load = 32'h0;
    do_load("lw 00 after rst", 2'b10, 1'b0, 32'h00, 32'h1122_3344);

    @(negedge ls_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
